// File: rtl/juego_luces_param_pkg.sv
// Shared types for the parametrised LED pattern engine.
// Pattern mode and bounce-direction encodings.
package juego_luces_param_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_ROT_R  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/juego_luces_param_pulsador_sync.sv
// Push-button conditioner: 2-FF synchronizer plus falling-edge detect.
// press_c is high for one cycle on a 1->0 transition of the synchronised key.
module juego_luces_param_pulsador_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press_c
);

    logic sync1;
    logic sync2;
    logic prev;

    // Idle level of an active-low key is 1, so reset everything there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press_c = prev & ~sync2;

endmodule

// File: rtl/juego_luces_param.sv
// LED pattern engine: bounce / rotate-left / rotate-right / fill over N_LEDS outputs,
// stepping at a prescaled rate divided by a button-adjustable speed level.
module juego_luces_param
    import juego_luces_param_pkg::*;
#(
    parameter int unsigned N_LEDS     = 8,
    parameter int unsigned PRESCALE   = 5_000_000,
    parameter int unsigned SPEED_W    = 4,
    parameter int unsigned SPEED_INIT = 8
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                RUN,
    input  logic [MODE_W-1:0]   MODE,
    input  logic                KEY_UP,
    input  logic                KEY_DOWN,
    output logic [N_LEDS-1:0]   LEDS,
    output logic [SPEED_W-1:0]  SPEED,
    output logic                STEP
);

    localparam int unsigned MAX_LVL = (2 ** SPEED_W) - 1;
    localparam int unsigned CNT_W   = $clog2(PRESCALE);

    logic               up_c;
    logic               down_c;
    logic [CNT_W-1:0]   pre_cnt;
    logic               base_tick_c;
    logic [SPEED_W-1:0] thr_c;
    logic [SPEED_W-1:0] div_q;
    logic [SPEED_W-1:0] div_d;
    logic [N_LEDS-1:0]  leds_d;
    logic               step_c;
    logic               mode_chg_c;
    mode_t              mode_q;
    dir_t               dir_q;
    dir_t               dir_d;

    juego_luces_param_pulsador_sync u_key_up (
        .clk     (CLK),
        .rst_n   (RSTn),
        .key     (KEY_UP),
        .press_c (up_c)
    );

    juego_luces_param_pulsador_sync u_key_down (
        .clk     (CLK),
        .rst_n   (RSTn),
        .key     (KEY_DOWN),
        .press_c (down_c)
    );

    // Base-rate prescaler; holds its count while frozen
    assign base_tick_c = RUN && (pre_cnt == CNT_W'(PRESCALE - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_cnt <= '0;
        end else if (RUN) begin
            pre_cnt <= base_tick_c ? '0 : pre_cnt + CNT_W'(1);
        end
    end

    // Saturating speed level; simultaneous presses cancel
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            SPEED <= SPEED_W'(SPEED_INIT);
        end else if (up_c && !down_c && (SPEED != SPEED_W'(MAX_LVL))) begin
            SPEED <= SPEED + SPEED_W'(1);
        end else if (down_c && !up_c && (SPEED != '0)) begin
            SPEED <= SPEED - SPEED_W'(1);
        end
    end

    assign thr_c      = SPEED_W'(MAX_LVL) - SPEED;
    assign mode_chg_c = (mode_q != mode_t'(MODE));

    // Pattern / direction state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            LEDS   <= N_LEDS'(1);
            dir_q  <= DIR_LEFT;
            div_q  <= '0;
            STEP   <= 1'b0;
            mode_q <= MODE_BOUNCE;
        end else begin
            LEDS   <= leds_d;
            dir_q  <= dir_d;
            div_q  <= div_d;
            STEP   <= step_c;
            mode_q <= mode_t'(MODE);
        end
    end

    // Next pattern: a mode switch reloads the start pattern and wins over a step
    always_comb begin
        leds_d = LEDS;
        dir_d  = dir_q;
        div_d  = div_q;
        step_c = 1'b0;
        if (mode_chg_c) begin
            leds_d = N_LEDS'(1);
            dir_d  = DIR_LEFT;
            div_d  = '0;
        end else if (base_tick_c) begin
            if (div_q >= thr_c) begin
                step_c = 1'b1;
                div_d  = '0;
                case (mode_q)
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            leds_d = {LEDS[N_LEDS-2:0], 1'b0};
                            if (LEDS[N_LEDS-2]) dir_d = DIR_RIGHT;
                        end else begin
                            leds_d = {1'b0, LEDS[N_LEDS-1:1]};
                            if (LEDS[1]) dir_d = DIR_LEFT;
                        end
                    end
                    MODE_ROT_L: leds_d = {LEDS[N_LEDS-2:0], LEDS[N_LEDS-1]};
                    MODE_ROT_R: leds_d = {LEDS[0], LEDS[N_LEDS-1:1]};
                    MODE_FILL:  leds_d = (&LEDS) ? '0 : {LEDS[N_LEDS-2:0], 1'b1};
                    default:    leds_d = LEDS;
                endcase
            end else begin
                div_d = div_q + SPEED_W'(1);
            end
        end
    end

endmodule
